// File: rtl/xlate_unit_pkg.sv
// Shared definitions for the address translation unit: exception codes,
// request types, CSR field positions, FSM states and the micro-TLB entry.
// No logic lives here beyond two small decode helpers.
package xlate_unit_pkg;

  // Exception codes reported on resp_ecode
  localparam logic [5:0] ECODE_TLBR = 6'h3F;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;

  // req_type encodings
  localparam logic [1:0] RT_FETCH = 2'b00;
  localparam logic [1:0] RT_LOAD  = 2'b01;
  localparam logic [1:0] RT_STORE = 2'b10;

  // CRMD field positions
  localparam int CRMD_PLV_LO  = 0;
  localparam int CRMD_PLV_HI  = 1;
  localparam int CRMD_DA      = 3;
  localparam int CRMD_PG      = 4;
  localparam int CRMD_DATM_LO = 7;
  localparam int CRMD_DATM_HI = 8;

  // DMW field positions (PLV enables occupy bits 3:0, one per level)
  localparam int DMW_MAT_LO  = 4;
  localparam int DMW_MAT_HI  = 5;
  localparam int DMW_PSEG_LO = 25;
  localparam int DMW_PSEG_HI = 27;
  localparam int DMW_VSEG_LO = 29;
  localparam int DMW_VSEG_HI = 31;

  // Page size code for a 2 MB page; anything else is treated as 4 KB
  localparam logic [5:0] PS_2M = 6'd21;

  typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_RESP} xl_state_e;

  // One cached translation, always stored at 4 KB granularity
  typedef struct packed {
    logic [19:0] vtag;
    logic [9:0]  asid;
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
  } utlb_entry_t;

  // Direct-window physical address: window segment replaces the top 3 bits
  function automatic logic [31:0] dmw_paddr(input logic [31:0] dmw, input logic [31:0] va);
    return {dmw[DMW_PSEG_HI:DMW_PSEG_LO], va[28:0]};
  endfunction

  // Page-invalid exception code depends on the access type
  function automatic logic [5:0] inv_ecode(input logic [1:0] t);
    logic [5:0] ec;
    case (t)
      RT_FETCH: ec = ECODE_PIF;
      RT_STORE: ec = ECODE_PIS;
      default:  ec = ECODE_PIL;
    endcase
    return ec;
  endfunction

endpackage

// File: rtl/xlate_unit_utlb_array.sv
// Micro-TLB: fully associative store of recent fault-free translations.
// Latency: combinational lookup; fill and flush take effect on the next edge.
// Backpressure: none; flush beats a same-cycle fill, fills go to a round-robin slot.
module utlb_array
  import xlate_unit_pkg::*;
#(
  parameter int UTLB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] i_lk_vtag,
  input  logic [9:0]  i_lk_asid,
  output logic        o_lk_hit,
  output utlb_entry_t o_lk_ent,
  input  logic        i_fill_en,
  input  utlb_entry_t i_fill_ent,
  input  logic        i_flush
);

  localparam int PTRW = $clog2(UTLB_DEPTH);

  logic [UTLB_DEPTH-1:0] r_vld;
  utlb_entry_t           r_ent [UTLB_DEPTH];
  logic [PTRW-1:0]       r_rr;

  // Valid bits and replacement pointer; flush wins over a same-cycle fill
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      r_rr  <= '0;
    end else if (i_flush) begin
      r_vld <= '0;
    end else if (i_fill_en) begin
      r_vld[r_rr] <= 1'b1;
      r_rr        <= (r_rr == PTRW'(UTLB_DEPTH - 1)) ? '0 : r_rr + 1'b1;
    end
  end

  // Entry payload, written on a fill; stale contents are masked by r_vld
  always_ff @(posedge clk) begin
    if (i_fill_en && !i_flush) r_ent[r_rr] <= i_fill_ent;
  end

  // Associative match on tag and ASID; lowest matching slot wins
  always_comb begin
    o_lk_hit = 1'b0;
    o_lk_ent = '0;
    for (int i = UTLB_DEPTH - 1; i >= 0; i--) begin
      if (r_vld[i] && r_ent[i].vtag == i_lk_vtag && r_ent[i].asid == i_lk_asid) begin
        o_lk_hit = 1'b1;
        o_lk_ent = r_ent[i];
      end
    end
  end

endmodule

// File: rtl/xlate_unit.sv
// Virtual-to-physical translation: direct, DMW window, micro-TLB or main-TLB lookup.
// Latency: 1 cycle for direct/window/micro-TLB hit, 2 cycles via the main TLB.
// Backpressure: response held until resp_ready; req_ready low in LOOKUP and stalled RESP.
module xlate_unit
  import xlate_unit_pkg::*;
#(
  parameter  int UTLB_DEPTH = 4,
  parameter  int TLBNUM     = 16,
  localparam int IDXW       = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_vaddr,
  input  logic [1:0]      req_type,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_paddr,
  output logic [1:0]      resp_mat,
  output logic            resp_except,
  output logic [5:0]      resp_ecode,
  output logic [18:0]     s_vppn,
  output logic            s_va_bit12,
  output logic [9:0]      s_asid,
  input  logic            s_found,
  input  logic [IDXW-1:0] s_index,
  input  logic [19:0]     s_ppn,
  input  logic [5:0]      s_ps,
  input  logic [1:0]      s_plv,
  input  logic [1:0]      s_mat,
  input  logic            s_d,
  input  logic            s_v,
  input  logic [8:0]      csr_crmd,
  input  logic [9:0]      csr_asid,
  input  logic [31:0]     csr_dmw0,
  input  logic [31:0]     csr_dmw1,
  input  logic            flush
);

  xl_state_e   r_state, w_state_nxt;
  logic [31:0] r_vaddr;
  logic [1:0]  r_type;
  logic [31:0] r_resp_paddr;
  logic [1:0]  r_resp_mat;
  logic        r_resp_except;
  logic [5:0]  r_resp_ecode;

  logic        w_accept, w_in_lookup, w_direct, w_dmw0_hit, w_dmw1_hit;
  logic [1:0]  w_plv;
  logic        w_u_hit;
  utlb_entry_t w_u_ent;
  logic        w_cls_miss, w_cls_exc;
  logic [31:0] w_cls_paddr;
  logic [1:0]  w_cls_mat;
  logic [5:0]  w_cls_ecode;
  logic        w_lk_exc;
  logic [31:0] w_lk_paddr;
  logic [19:0] w_lk_ppn4k;
  logic [1:0]  w_lk_mat;
  logic [5:0]  w_lk_ecode;
  logic        w_fill_en;
  utlb_entry_t w_fill_ent;
  logic        w_unused;

  assign req_ready   = (r_state == ST_IDLE) || (r_state == ST_RESP && resp_ready);
  assign w_accept    = req_valid && req_ready;
  assign w_in_lookup = (r_state == ST_LOOKUP);
  assign resp_valid  = (r_state == ST_RESP);
  assign resp_paddr  = r_resp_paddr;
  assign resp_mat    = r_resp_mat;
  assign resp_except = r_resp_except;
  assign resp_ecode  = r_resp_ecode;

  // Main-TLB key is only driven while a lookup is in flight
  assign s_vppn     = w_in_lookup ? r_vaddr[31:13] : '0;
  assign s_va_bit12 = w_in_lookup ? r_vaddr[12] : 1'b0;
  assign s_asid     = w_in_lookup ? csr_asid : '0;

  assign w_plv      = csr_crmd[CRMD_PLV_HI:CRMD_PLV_LO];
  assign w_direct   = csr_crmd[CRMD_DA] || !csr_crmd[CRMD_PG];
  assign w_dmw0_hit = !w_direct && csr_dmw0[w_plv] &&
                      (req_vaddr[31:29] == csr_dmw0[DMW_VSEG_HI:DMW_VSEG_LO]);
  assign w_dmw1_hit = !w_direct && csr_dmw1[w_plv] &&
                      (req_vaddr[31:29] == csr_dmw1[DMW_VSEG_HI:DMW_VSEG_LO]);

  utlb_array #(.UTLB_DEPTH(UTLB_DEPTH)) u_utlb (
    .clk        (clk),
    .reset      (reset),
    .i_lk_vtag  (req_vaddr[31:12]),
    .i_lk_asid  (csr_asid),
    .o_lk_hit   (w_u_hit),
    .o_lk_ent   (w_u_ent),
    .i_fill_en  (w_fill_en),
    .i_fill_ent (w_fill_ent),
    .i_flush    (flush)
  );

  // Classify the incoming request: direct, window, micro-TLB hit, or miss
  always_comb begin
    w_cls_miss  = 1'b0;
    w_cls_exc   = 1'b0;
    w_cls_ecode = '0;
    w_cls_paddr = req_vaddr;
    w_cls_mat   = csr_crmd[CRMD_DATM_HI:CRMD_DATM_LO];
    if (w_direct) begin
      w_cls_paddr = req_vaddr;
    end else if (w_dmw0_hit) begin
      w_cls_paddr = dmw_paddr(csr_dmw0, req_vaddr);
      w_cls_mat   = csr_dmw0[DMW_MAT_HI:DMW_MAT_LO];
    end else if (w_dmw1_hit) begin
      w_cls_paddr = dmw_paddr(csr_dmw1, req_vaddr);
      w_cls_mat   = csr_dmw1[DMW_MAT_HI:DMW_MAT_LO];
    end else if (w_u_hit) begin
      w_cls_paddr = {w_u_ent.ppn, req_vaddr[11:0]};
      w_cls_mat   = w_u_ent.mat;
      if (w_plv > w_u_ent.plv) begin
        w_cls_exc   = 1'b1;
        w_cls_ecode = ECODE_PPI;
      end else if (req_type == RT_STORE && !w_u_ent.d) begin
        w_cls_exc   = 1'b1;
        w_cls_ecode = ECODE_PME;
      end
      if (w_cls_exc) begin
        w_cls_paddr = '0;
        w_cls_mat   = '0;
      end
    end else begin
      w_cls_miss = 1'b1;
    end
  end

  // Evaluate the main-TLB result; 2 MB pages are folded to a 4 KB ppn for caching
  always_comb begin
    w_lk_exc   = 1'b0;
    w_lk_ecode = '0;
    w_lk_ppn4k = (s_ps == PS_2M) ? {s_ppn[19:9], r_vaddr[20:12]} : s_ppn;
    w_lk_paddr = (s_ps == PS_2M) ? {s_ppn[19:9], r_vaddr[20:0]} : {s_ppn, r_vaddr[11:0]};
    w_lk_mat   = s_mat;
    if (!s_found) begin
      w_lk_exc   = 1'b1;
      w_lk_ecode = ECODE_TLBR;
    end else if (!s_v) begin
      w_lk_exc   = 1'b1;
      w_lk_ecode = inv_ecode(r_type);
    end else if (w_plv > s_plv) begin
      w_lk_exc   = 1'b1;
      w_lk_ecode = ECODE_PPI;
    end else if (r_type == RT_STORE && !s_d) begin
      w_lk_exc   = 1'b1;
      w_lk_ecode = ECODE_PME;
    end
    if (w_lk_exc) begin
      w_lk_paddr = '0;
      w_lk_mat   = '0;
    end
  end

  assign w_fill_en  = w_in_lookup && !w_lk_exc;
  assign w_fill_ent = '{vtag: r_vaddr[31:12], asid: csr_asid, ppn: w_lk_ppn4k,
                        plv: s_plv, mat: s_mat, d: s_d};

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: misses detour through LOOKUP, everything else responds directly
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = w_cls_miss ? ST_LOOKUP : ST_RESP;
      ST_LOOKUP: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          if (!req_valid)      w_state_nxt = ST_IDLE;
          else if (w_cls_miss) w_state_nxt = ST_LOOKUP;
          else                 w_state_nxt = ST_RESP;
        end
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture and response registers; response only changes when entering RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vaddr       <= '0;
      r_type        <= '0;
      r_resp_paddr  <= '0;
      r_resp_mat    <= '0;
      r_resp_except <= 1'b0;
      r_resp_ecode  <= '0;
    end else if (w_in_lookup) begin
      r_resp_paddr  <= w_lk_paddr;
      r_resp_mat    <= w_lk_mat;
      r_resp_except <= w_lk_exc;
      r_resp_ecode  <= w_lk_ecode;
    end else if (w_accept) begin
      r_vaddr <= req_vaddr;
      r_type  <= req_type;
      if (!w_cls_miss) begin
        r_resp_paddr  <= w_cls_paddr;
        r_resp_mat    <= w_cls_mat;
        r_resp_except <= w_cls_exc;
        r_resp_ecode  <= w_cls_ecode;
      end
    end
  end

  // Inputs and fields that translation does not consume
  assign w_unused = ^{s_index, csr_crmd[6:5], csr_crmd[2], csr_dmw0[28], csr_dmw0[24:6],
                      csr_dmw1[28], csr_dmw1[24:6], w_u_ent.vtag, w_u_ent.asid};

endmodule

// File: tb/tb_xlate_unit.sv
// Directed bench for xlate_unit: reset, direct/window/TLB paths, exceptions,
// micro-TLB replacement and flush, back-to-back and held responses.
`timescale 1ns/1ps
module tb_xlate_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_vaddr;
  logic [1:0]  req_type;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_paddr;
  logic [1:0]  resp_mat;
  logic        resp_except;
  logic [5:0]  resp_ecode;
  logic [18:0] s_vppn;
  logic        s_va_bit12;
  logic [9:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index;
  logic [19:0] s_ppn;
  logic [5:0]  s_ps;
  logic [1:0]  s_plv, s_mat;
  logic        s_d, s_v;
  logic [8:0]  csr_crmd;
  logic [9:0]  csr_asid;
  logic [31:0] csr_dmw0, csr_dmw1;
  logic        flush;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          got_lat;
  logic [31:0] got_pa;
  logic [1:0]  got_mat;
  logic        got_exc;
  logic [5:0]  got_ec;
  logic [18:0] got_vppn;
  logic [9:0]  got_asid;

  always #5 clk = ~clk;

  xlate_unit #(.UTLB_DEPTH(4), .TLBNUM(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr), .req_type(req_type),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_mat(resp_mat), .resp_except(resp_except), .resp_ecode(resp_ecode),
    .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn), .s_ps(s_ps), .s_plv(s_plv),
    .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
    .csr_crmd(csr_crmd), .csr_asid(csr_asid), .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
    .flush(flush)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tlb_set(input logic f, input logic v, input logic [19:0] ppn, input logic [5:0] ps,
                         input logic [1:0] plv, input logic [1:0] mat, input logic d);
    s_found = f; s_v = v; s_ppn = ppn; s_ps = ps; s_plv = plv; s_mat = mat; s_d = d;
  endtask

  // One request from IDLE; fl: 0 none, 1 flush with acceptance, 2 flush in the next cycle
  task automatic xact(input logic [31:0] va, input logic [1:0] ty, input int fl);
    req_vaddr = va; req_type = ty; req_valid = 1'b1;
    if (fl == 1) flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    got_lat  = 1;
    got_vppn = s_vppn;
    got_asid = s_asid;
    if (fl == 2) flush = 1'b1;
    while (!resp_valid && got_lat < 8) begin
      step();
      flush = 1'b0;
      got_lat++;
    end
    got_pa = resp_paddr; got_mat = resp_mat; got_exc = resp_except; got_ec = resp_ecode;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [31:0] va, input logic [1:0] ty, input int fl,
                     input int e_lat, input logic [31:0] e_pa, input logic [5:0] e_ec);
    xact(va, ty, fl);
    chk_eq({tag, ".lat"}, got_lat, e_lat);
    chk_eq({tag, ".exc"}, {31'd0, got_exc}, {31'd0, e_ec != 6'd0});
    chk_eq({tag, ".ecode"}, {26'd0, got_ec}, {26'd0, e_ec});
    if (e_ec == 6'd0) chk_eq({tag, ".paddr"}, got_pa, e_pa);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 0; req_vaddr = 0; req_type = 2'b01; resp_ready = 0; flush = 0; s_index = 0;
    csr_crmd = 9'h008; csr_asid = 10'h005; csr_dmw0 = 0; csr_dmw1 = 0;
    tlb_set(0, 0, 20'h0, 6'd12, 2'd0, 2'd0, 0);
    reset = 1;
    step(); step();
    chk_eq("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    chk_eq("rst.resp_paddr", resp_paddr, 32'd0);
    chk_eq("rst.resp_ecode", {26'd0, resp_ecode}, 32'd0);
    chk_eq("rst.resp_mat_exc", {29'd0, resp_mat, resp_except}, 32'd0);
    reset = 0;
    step();
    chk_eq("rst.req_ready", {31'd0, req_ready}, 32'd1);
    chk_eq("rst.s_vppn", {13'd0, s_vppn}, 32'd0);

    // Direct translation, DATM=1
    csr_crmd = 9'h088;
    run("da", 32'h1C00_0100, 2'b01, 0, 1, 32'h1C00_0100, 6'h00);
    chk_eq("da.mat", {30'd0, got_mat}, 32'd1);

    // Direct mapping windows
    csr_crmd = 9'h010; csr_dmw0 = 32'h9000_0009; csr_dmw1 = 32'hA200_0031;
    run("dmw0", 32'h9FC0_0000, 2'b01, 0, 1, 32'h1FC0_0000, 6'h00);
    chk_eq("dmw0.mat", {30'd0, got_mat}, 32'd0);
    run("dmw1", 32'hA000_1234, 2'b00, 0, 1, 32'h2000_1234, 6'h00);
    chk_eq("dmw1.mat", {30'd0, got_mat}, 32'd3);
    // PLV1 not enabled in DMW0: falls through to the TLB, which reports a refill
    csr_crmd = 9'h011;
    run("dmw_plv", 32'h9FC0_0000, 2'b01, 0, 2, 32'h0, 6'h3F);
    csr_crmd = 9'h010;

    // Main TLB miss then micro-TLB hit (bogus s_ppn proves the hit is cached)
    tlb_set(1, 1, 20'h00123, 6'd12, 2'd0, 2'd1, 1);
    run("miss", 32'h0040_2ABC, 2'b01, 0, 2, 32'h0012_3ABC, 6'h00);
    chk_eq("miss.s_vppn", {13'd0, got_vppn}, 32'h201);
    chk_eq("miss.s_asid", {22'd0, got_asid}, 32'h005);
    chk_eq("miss.mat", {30'd0, got_mat}, 32'd1);
    tlb_set(1, 1, 20'hFFFFF, 6'd12, 2'd0, 2'd1, 1);
    run("hit", 32'h0040_2ABC, 2'b01, 0, 1, 32'h0012_3ABC, 6'h00);
    chk_eq("hit.s_vppn", {13'd0, got_vppn}, 32'h0);
    run("hit_st", 32'h0040_2ABC, 2'b10, 0, 1, 32'h0012_3ABC, 6'h00);
    csr_crmd = 9'h013;
    run("hit_ppi", 32'h0040_2ABC, 2'b01, 0, 1, 32'h0, 6'h07);
    csr_crmd = 9'h010;

    // Lookup exceptions; a faulting page must not be cached
    tlb_set(1, 1, 20'h00200, 6'd12, 2'd0, 2'd0, 0);
    run("pme", 32'h0050_0000, 2'b10, 0, 2, 32'h0, 6'h04);
    run("pme2", 32'h0050_0000, 2'b10, 0, 2, 32'h0, 6'h04);
    tlb_set(0, 1, 20'h00200, 6'd12, 2'd0, 2'd0, 1);
    run("tlbr", 32'h0060_0000, 2'b01, 0, 2, 32'h0, 6'h3F);
    tlb_set(1, 0, 20'h00200, 6'd12, 2'd0, 2'd0, 1);
    run("pif", 32'h0070_0000, 2'b00, 0, 2, 32'h0, 6'h03);
    run("pis", 32'h0070_0000, 2'b10, 0, 2, 32'h0, 6'h02);

    // 2 MB page, then cached hit at 4 KB granularity
    tlb_set(1, 1, 20'h12345, 6'd21, 2'd0, 2'd0, 1);
    run("2m", 32'h00A5_4321, 2'b01, 0, 2, 32'h1225_4321, 6'h00);
    tlb_set(1, 1, 20'hFFFFF, 6'd21, 2'd0, 2'd0, 1);
    run("2m_hit", 32'h00A5_4321, 2'b01, 0, 1, 32'h1225_4321, 6'h00);

    // Flush while idle clears the cache
    flush = 1; step(); flush = 0;
    tlb_set(1, 1, 20'h00123, 6'd12, 2'd0, 2'd1, 1);
    run("postflush", 32'h0040_2ABC, 2'b01, 0, 2, 32'h0012_3ABC, 6'h00);

    // Five distinct pages through four slots: first page is evicted
    for (int k = 0; k < 5; k++) begin
      tlb_set(1, 1, 20'h00400 + 20'(k), 6'd12, 2'd0, 2'd0, 1);
      run($sformatf("rr%0d", k), 32'h0100_00AB + 32'(k) * 32'h1000, 2'b01, 0, 2,
          32'h0040_00AB + 32'(k) * 32'h1000, 6'h00);
    end
    tlb_set(1, 1, 20'hFFFFF, 6'd12, 2'd0, 2'd0, 1);
    run("rr4_hit", 32'h0100_40AB, 2'b01, 0, 1, 32'h0040_40AB, 6'h00);
    tlb_set(1, 1, 20'h00400, 6'd12, 2'd0, 2'd0, 1);
    run("rr0_wrap", 32'h0100_00AB, 2'b01, 0, 2, 32'h0040_00AB, 6'h00);

    // Back-to-back hits on pages 2 and 3
    tlb_set(1, 1, 20'hFFFFF, 6'd12, 2'd0, 2'd0, 1);
    req_vaddr = 32'h0100_20AB; req_type = 2'b01; req_valid = 1;
    step();
    chk_eq("b2b_a.vld", {31'd0, resp_valid}, 32'd1);
    chk_eq("b2b_a.pa", resp_paddr, 32'h0040_20AB);
    resp_ready = 1; req_vaddr = 32'h0100_30AB;
    step();
    chk_eq("b2b_b.vld", {31'd0, resp_valid}, 32'd1);
    chk_eq("b2b_b.pa", resp_paddr, 32'h0040_30AB);
    req_valid = 0;
    step();
    resp_ready = 0;

    // Flush together with acceptance uses pre-flush contents
    run("fl_acc", 32'h0100_20AB, 2'b01, 1, 1, 32'h0040_20AB, 6'h00);
    tlb_set(1, 1, 20'h00402, 6'd12, 2'd0, 2'd0, 1);
    run("fl_acc2", 32'h0100_20AB, 2'b01, 0, 2, 32'h0040_20AB, 6'h00);
    // Flush during LOOKUP: response delivered, no fill
    tlb_set(1, 1, 20'h00405, 6'd12, 2'd0, 2'd0, 1);
    run("fl_lk", 32'h0100_50AB, 2'b01, 2, 2, 32'h0040_50AB, 6'h00);
    run("fl_lk2", 32'h0100_50AB, 2'b01, 0, 2, 32'h0040_50AB, 6'h00);
    run("fl_lk3", 32'h0100_50AB, 2'b01, 0, 1, 32'h0040_50AB, 6'h00);

    // Held response for three cycles, then reset while in RESP
    req_vaddr = 32'h0100_50AB; req_valid = 1;
    step();
    req_vaddr = 32'h0100_20AB;
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("hold%0d.vld", i), {31'd0, resp_valid}, 32'd1);
      chk_eq($sformatf("hold%0d.pa", i), resp_paddr, 32'h0040_50AB);
      chk_eq($sformatf("hold%0d.rdy", i), {31'd0, req_ready}, 32'd0);
      step();
    end
    reset = 1;
    step();
    reset = 0; req_valid = 0;
    chk_eq("rst_resp.vld", {31'd0, resp_valid}, 32'd0);
    chk_eq("rst_resp.pa", resp_paddr, 32'd0);
    chk_eq("rst_resp.rdy", {31'd0, req_ready}, 32'd1);
    run("post_rst", 32'h0100_50AB, 2'b01, 0, 2, 32'h0040_50AB, 6'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xlate_unit.md
XLATE_UNIT -- requirements
Module: xlate_unit

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- UTLB_DEPTH, 4, micro-TLB entries (power of two, 2..16).
- TLBNUM, 16, main TLB entries; index width IDXW = clog2(TLBNUM).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning. One clock; reset is synchronous and active-high.
- clk in 1 system clock
- reset in 1 synchronous active-high reset
- req_valid in 1; req_ready out 1; req_vaddr in 32; req_type in 2 (00 fetch, 01 load, 10 store)
- resp_valid out 1; resp_ready in 1; resp_paddr out 32; resp_mat out 2; resp_except out 1; resp_ecode out 6
- s_vppn out 19; s_va_bit12 out 1; s_asid out 10: main-TLB search key
- s_found in 1; s_index in IDXW; s_ppn in 20; s_ps in 6; s_plv in 2; s_mat in 2; s_d in 1; s_v in 1: combinational search result, valid in the same cycle as the key
- csr_crmd in 9 (PLV[1:0], DA[3], PG[4], DATM[8:7]); csr_asid in 10; csr_dmw0 in 32; csr_dmw1 in 32
- flush in 1: invalidate micro-TLB (TLBWR/TLBFILL/INVTLB/ASID write)

Function
REQ-010 SHALL implement FSM IDLE, LOOKUP, RESP; request accepted when req_valid && req_ready.
REQ-011 req_ready SHALL be 1 in IDLE, 1 in RESP only when resp_ready=1, and 0 in LOOKUP.
REQ-012 On acceptance, SHALL classify in the same cycle: DA=1 -> direct; PG=1 and DMWn hits (DMWn[PLV bit for CRMD.PLV]=1 and vaddr[31:29]==DMWn[31:29], DMW0 taking priority) -> window; micro-TLB hit -> hit; else miss.
REQ-013 Direct SHALL give paddr=vaddr, mat=DATM; window SHALL give paddr={DMWn[27:25],vaddr[28:0]}, mat=DMWn[5:4]; both respond with no exception.
REQ-014 Direct/window/hit SHALL go to RESP with resp_valid=1 on the cycle after acceptance (latency 1).
REQ-015 Miss SHALL go to LOOKUP, drive s_vppn=vaddr[31:13], s_va_bit12=vaddr[12], s_asid=csr_asid, capture the result at the end of that cycle, then go to RESP (latency 2).
REQ-016 Exception priority in LOOKUP SHALL be: !s_found -> TLBR 0x3F; !s_v -> PIF 0x03, PIL 0x01 or PIS 0x02 by type; CRMD.PLV > s_plv -> PPI 0x07; store && !s_d -> PME 0x04.
REQ-017 Translation SHALL give paddr={s_ppn,vaddr[11:0]} when s_ps=12, and {s_ppn[19:9],vaddr[20:0]} when s_ps=21.
REQ-018 A micro-TLB entry SHALL hold: valid; tag = vaddr[31:12] and asid; ppn4k[19:0]; plv; mat; d.
REQ-019 A hit SHALL require an equal tag and equal ASID.
REQ-020 A hit SHALL re-run the PPI/PME checks against the stored plv/d.
REQ-021 Only fault-free LOOKUP results SHALL be filled into the micro-TLB, at the slot given by a round-robin pointer that wraps from UTLB_DEPTH-1 to 0.
REQ-022 RESP SHALL hold all resp_* stable until resp_ready=1.
- With resp_ready and req_valid both high: go directly to the next request's path (back-to-back, one per cycle on hits).
- With resp_ready high and req_valid low: go to IDLE.
REQ-023 flush SHALL clear all valid bits on the next edge.
- flush in LOOKUP: suppress that fill; the response is still delivered.
- flush together with an accepted request: classify against the pre-flush contents.
REQ-024 s_* outputs SHALL be 0 outside LOOKUP.

Reset
REQ-030 On reset the block SHALL go to IDLE.
REQ-031 On reset SHALL clear all micro-TLB valid bits and set the RR pointer to 0.
REQ-032 On reset SHALL set resp_valid=0, resp_paddr=0, resp_mat=0, resp_except=0, resp_ecode=0; req_ready=1 in the first cycle after reset.
REQ-033 Reset during LOOKUP or RESP SHALL discard the pending response; no fill occurs.

Structure
REQ-040 Shared package SHALL hold the ecode constants (TLBR, PIL, PIS, PIF, PME, PPI), the req_type encodings, and the CRMD/DMW field-position constants.
REQ-041 Micro-TLB storage and match SHALL be one sub-module, utlb_array (parameter UTLB_DEPTH; ports lookup, fill, flush).

Verification
REQ-050 DA=1, load 0x1C000100 -> paddr 0x1C000100, no exception, 1 cycle.
REQ-051 PG=1, DMW0=0x9000_0009, PLV0, vaddr 0x9FC0_0000 -> paddr 0x1FC0_0000, mat 0, no exception.
REQ-052 PG=1, miss, s_found=1, s_v=1, s_ppn=0x00123, s_ps=12, vaddr 0x0040_2ABC:
- first request -> paddr 0x00123ABC at 2-cycle latency;
- repeat -> 1-cycle hit, with s_vppn held at 0.
REQ-053 Store to a page with s_d=0 -> PME 0x04, no fill; s_found=0 -> TLBR 0x3F.
REQ-054 With UTLB_DEPTH=4, fill 5 distinct pages; the first page then misses (RR wrap). flush mid-LOOKUP -> response delivered, entry not cached.
REQ-055 resp_ready held low 3 cycles -> resp_* stable and req_ready=0; reset in RESP -> resp_valid=0 next cycle.
